// File: rtl/chipset_bus_pkg.sv
// chipset_bus shared types and field widths.
// Used by the bus FSM and the region decoder.
package chipset_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    localparam int MAX_REG = 8;
    localparam int WAIT_W  = 4;
    localparam int SIZE_W  = 5;
    localparam int IDX_W   = $clog2(MAX_REG);

endpackage

// File: rtl/chipset_region_decode.sv
// Combinational address-to-region decoder.
// The lowest matching region index wins.
module chipset_region_decode
    import chipset_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int N_REG  = 3,
    parameter logic [N_REG*ADDR_W-1:0] REG_BASE      = {32'h800, 32'h400, 32'h000},
    parameter logic [N_REG*SIZE_W-1:0] REG_SIZE_LOG2 = {5'd8, 5'd7, 5'd10},
    parameter logic [N_REG-1:0]        REG_RO        = 3'b010
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_hit,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_ro,
    output logic [ADDR_W-1:0] o_offset
);

    logic [ADDR_W-1:0] w_mask;

    // Scan downwards so a lower index overrides a higher one.
    always_comb begin
        o_hit    = 1'b0;
        o_idx    = '0;
        o_ro     = 1'b0;
        o_offset = '0;
        w_mask   = '0;
        for (int i = N_REG - 1; i >= 0; i--) begin
            w_mask = ~((ADDR_W'(1) << REG_SIZE_LOG2[i*SIZE_W +: SIZE_W])
                       - ADDR_W'(1));
            if ((i_addr & w_mask) == (REG_BASE[i*ADDR_W +: ADDR_W] & w_mask)) begin
                o_hit    = 1'b1;
                o_idx    = IDX_W'(i);
                o_ro     = REG_RO[i];
                o_offset = i_addr & ~w_mask;
            end
        end
    end

endmodule

// File: rtl/chipset_bus.sv
// Memory-map chipset: decodes CPU accesses to N devices,
// inserts per-region wait states and returns a ready pulse.
module chipset_bus
    import chipset_bus_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int N_REG  = 3,
    parameter logic [N_REG*ADDR_W-1:0] REG_BASE      = {32'h800, 32'h400, 32'h000},
    parameter logic [N_REG*SIZE_W-1:0] REG_SIZE_LOG2 = {5'd8, 5'd7, 5'd10},
    parameter logic [N_REG*WAIT_W-1:0] REG_WAIT      = {4'd3, 4'd1, 4'd0},
    parameter logic [N_REG-1:0]        REG_RO        = 3'b010
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_cpu_req,
    input  logic                    i_cpu_we,
    input  logic [ADDR_W-1:0]       i_cpu_addr,
    input  logic [DATA_W-1:0]       i_cpu_wdata,
    output logic                    o_cpu_ready,
    output logic                    o_cpu_err,
    output logic [DATA_W-1:0]       o_cpu_rdata,
    output logic [N_REG-1:0]        o_dev_en,
    output logic [N_REG-1:0]        o_dev_we,
    output logic [ADDR_W-1:0]       o_dev_addr,
    output logic [DATA_W-1:0]       o_dev_wdata,
    input  logic [N_REG*DATA_W-1:0] i_dev_rdata
);

    state_t            r_state;
    state_t            w_next;
    logic [WAIT_W-1:0] r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_off;
    logic [DATA_W-1:0] r_wdata;
    logic [IDX_W-1:0]  r_idx;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;

    logic              w_hit;
    logic [IDX_W-1:0]  w_idx;
    logic              w_ro;
    logic [ADDR_W-1:0] w_off;
    logic              w_err;
    logic              w_accept;
    logic [WAIT_W-1:0] w_wait;
    logic [N_REG-1:0]  w_sel;
    logic [DATA_W-1:0] w_rdata;

    chipset_region_decode #(
        .ADDR_W        (ADDR_W),
        .N_REG         (N_REG),
        .REG_BASE      (REG_BASE),
        .REG_SIZE_LOG2 (REG_SIZE_LOG2),
        .REG_RO        (REG_RO)
    ) u_decode (
        .i_addr   (i_cpu_addr),
        .o_hit    (w_hit),
        .o_idx    (w_idx),
        .o_ro     (w_ro),
        .o_offset (w_off)
    );

    assign w_err    = !w_hit || (i_cpu_we && w_ro);
    assign w_accept = (r_state == ST_IDLE) && i_cpu_req;

    // Per-index lookups for the new request and the latched one.
    always_comb begin
        w_wait  = '0;
        w_sel   = '0;
        w_rdata = '0;
        for (int i = 0; i < N_REG; i++) begin
            if (w_idx == IDX_W'(i))
                w_wait = REG_WAIT[i*WAIT_W +: WAIT_W];
            if (r_idx == IDX_W'(i)) begin
                w_sel[i] = 1'b1;
                w_rdata  = i_dev_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (i_cpu_req) w_next = w_err ? ST_RESP : ST_ACCESS;
            ST_ACCESS: if (r_cnt == '0) w_next = ST_RESP;
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_off   <= '0;
            r_wdata <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we    <= i_cpu_we;
                r_off   <= w_off;
                r_wdata <= i_cpu_wdata;
                r_idx   <= w_idx;
                r_cnt   <= w_err ? '0 : w_wait;
                r_err   <= w_err;
                r_rdata <= '0;
            end else if (r_state == ST_ACCESS) begin
                if (r_cnt != '0)
                    r_cnt <= r_cnt - 1'b1;
                else if (!r_we)
                    r_rdata <= w_rdata;
            end
        end
    end

    assign o_cpu_ready = (r_state == ST_RESP);
    assign o_cpu_err   = r_err;
    assign o_cpu_rdata = r_rdata;
    assign o_dev_en    = (r_state == ST_ACCESS) ? w_sel : '0;
    assign o_dev_we    = (r_state == ST_ACCESS && r_we && r_cnt == '0)
                         ? w_sel : '0;
    assign o_dev_addr  = r_off;
    assign o_dev_wdata = r_wdata;

endmodule

// File: tb/tb_chipset_bus.sv
// Directed self-checking bench for chipset_bus
// with default region map.
module tb_chipset_bus;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        err;
    logic [31:0] rdata;
    logic [2:0]  dev_en;
    logic [2:0]  dev_we;
    logic [31:0] dev_addr;
    logic [31:0] dev_wdata;
    logic [95:0] dev_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    chipset_bus dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cpu_req   (req),
        .i_cpu_we    (we),
        .i_cpu_addr  (addr),
        .i_cpu_wdata (wdata),
        .o_cpu_ready (ready),
        .o_cpu_err   (err),
        .o_cpu_rdata (rdata),
        .o_dev_en    (dev_en),
        .o_dev_we    (dev_we),
        .o_dev_addr  (dev_addr),
        .o_dev_wdata (dev_wdata),
        .i_dev_rdata (dev_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic access(input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] en,
                          input logic [31:0] off, input int nwait,
                          input logic e, input logic [31:0] exp_rd);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0;
        if (!e) begin
            for (int k = 0; k <= nwait; k++) begin
                chk($sformatf("en_%h_%0d", a, k), 32'(dev_en), 32'(en));
                chk($sformatf("we_%h_%0d", a, k), 32'(dev_we),
                    (w && k == nwait) ? 32'(en) : 32'd0);
                chk($sformatf("off_%h_%0d", a, k), dev_addr, off);
                chk($sformatf("rdy0_%h_%0d", a, k), 32'(ready), 32'd0);
                if (w) chk($sformatf("wd_%h", a), dev_wdata, d);
                @(negedge clk);
            end
        end else begin
            chk($sformatf("en_err_%h", a), 32'(dev_en), 32'd0);
        end
        chk($sformatf("rdy_%h", a), 32'(ready), 32'd1);
        chk($sformatf("err_%h", a), 32'(err), 32'(e));
        chk($sformatf("rd_%h", a), rdata, exp_rd);
        @(negedge clk);
        chk($sformatf("idle_%h", a), 32'(ready), 32'd0);
    endtask

    logic [8:0] rdy_v;
    logic [8:0] en_v;

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        dev_rdata = {32'h55AA55AA, 32'h12345678, 32'hDEADBEEF};
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_en", 32'(dev_en), 32'd0);
        chk("rst_we", 32'(dev_we), 32'd0);
        chk("rst_addr", dev_addr, 32'd0);
        chk("rst_wdata", dev_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        access(1'b0, 32'h004, 32'h0, 3'b001, 32'h004, 0, 1'b0, 32'hDEADBEEF);
        access(1'b0, 32'h41C, 32'h0, 3'b010, 32'h01C, 1, 1'b0, 32'h12345678);
        access(1'b1, 32'h8F0, 32'hCAFE0001, 3'b100, 32'h0F0, 3, 1'b0, 32'h0);
        access(1'b1, 32'h400, 32'h11111111, 3'b000, 32'h0, 0, 1'b1, 32'h0);
        access(1'b0, 32'h480, 32'h0, 3'b000, 32'h0, 0, 1'b1, 32'h0);
        access(1'b0, 32'h8FC, 32'h0, 3'b100, 32'h0FC, 3, 1'b0, 32'h55AA55AA);

        // Held request on region 0: one accept every 3 cycles.
        req = 1'b1; we = 1'b0; addr = 32'h010;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            rdy_v[k] = ready;
            en_v[k]  = dev_en[0];
        end
        req = 1'b0;
        chk("held_ready", 32'(rdy_v), 32'h092);
        chk("held_en", 32'(en_v), 32'h049);
        @(negedge clk);
        @(negedge clk);

        // Reset during the second ACCESS cycle of a region-2 write.
        req = 1'b1; we = 1'b1; addr = 32'h804; wdata = 32'hA5A5A5A5;
        @(negedge clk);
        req = 1'b0;
        chk("ab_we0", 32'(dev_we), 32'd0);
        chk("ab_en0", 32'(dev_en), 32'h4);
        @(negedge clk);
        chk("ab_we1", 32'(dev_we), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("ab_en", 32'(dev_en), 32'd0);
        chk("ab_we", 32'(dev_we), 32'd0);
        chk("ab_rdy", 32'(ready), 32'd0);
        chk("ab_addr", dev_addr, 32'd0);
        chk("ab_wdata", dev_wdata, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("ab_quiet_rdy_%0d", k), 32'(ready), 32'd0);
            chk($sformatf("ab_quiet_we_%0d", k), 32'(dev_we), 32'd0);
        end
        access(1'b0, 32'h004, 32'h0, 3'b001, 32'h004, 0, 1'b0, 32'hDEADBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
